// File: rtl/writeback_stage.sv
// Writeback stage: decodes the retiring instruction, extracts and extends load data,
// and presents a one-cycle-registered register-file write with retire information.
module writeback_stage #(
    parameter int XLEN     = 32,
    parameter int RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                rstf,
    input  logic [31:0]         t_instr,
    input  logic                t_instr_valid,
    output logic                t_instr_ready,
    input  logic [XLEN-1:0]     t_pc,
    input  logic [XLEN-1:0]     t_alu_result,
    input  logic [XLEN-1:0]     t_load_data,
    input  logic                i_hold,
    input  logic                i_flush,
    output logic [4:0]          rd,
    output logic [XLEN-1:0]     rd_value,
    output logic                we,
    output logic                retire_valid,
    output logic [XLEN-1:0]     retire_pc,
    output logic [RETIRE_W-1:0] retire_count,
    output logic                o_misaligned,
    output logic                o_illegal
);
    localparam int OFF_W = $clog2(XLEN / 8);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    logic [6:0]      opcode_s;
    logic [2:0]      funct3_s;
    logic [4:0]      rd_s;
    logic [OFF_W-1:0] off_s;
    logic [OFF_W-1:0] size_mask_s;
    logic [XLEN-1:0] shifted_s;
    logic [XLEN-1:0] load_value_s;
    logic [XLEN-1:0] value_s;
    logic            load_illegal_s;
    logic            load_misaligned_s;
    logic            writes_s;
    logic            illegal_s;
    logic            misaligned_s;
    logic            accept_s;
    logic            unused_s;

    assign opcode_s      = t_instr[6:0];
    assign rd_s          = t_instr[11:7];
    assign funct3_s      = t_instr[14:12];
    assign off_s         = t_alu_result[OFF_W-1:0];
    assign shifted_s     = t_load_data >> {off_s, 3'b000};
    assign t_instr_ready = rstf & ~i_hold;
    assign accept_s      = t_instr_valid & t_instr_ready;
    assign unused_s      = &{1'b0, t_instr[31:15]};

    // Load lane selection, sign/zero extension and access-size alignment mask.
    always_comb begin
        load_value_s   = '0;
        size_mask_s    = '0;
        load_illegal_s = 1'b0;
        case (funct3_s)
            3'b000: load_value_s = XLEN'($signed(shifted_s[7:0]));
            3'b100: load_value_s = XLEN'(shifted_s[7:0]);
            3'b001: begin
                load_value_s = XLEN'($signed(shifted_s[15:0]));
                size_mask_s  = OFF_W'(3'd1);
            end
            3'b101: begin
                load_value_s = XLEN'(shifted_s[15:0]);
                size_mask_s  = OFF_W'(3'd1);
            end
            3'b010: begin
                load_value_s = XLEN'($signed(shifted_s[31:0]));
                size_mask_s  = OFF_W'(3'd3);
            end
            3'b110: begin
                if (XLEN == 64) begin
                    load_value_s = XLEN'(shifted_s[31:0]);
                    size_mask_s  = OFF_W'(3'd3);
                end else begin
                    load_illegal_s = 1'b1;
                end
            end
            3'b011: begin
                if (XLEN == 64) begin
                    load_value_s = t_load_data;
                    size_mask_s  = OFF_W'(3'd7);
                end else begin
                    load_illegal_s = 1'b1;
                end
            end
            default: load_illegal_s = 1'b1;
        endcase
        load_misaligned_s = ~load_illegal_s & ((off_s & size_mask_s) != '0);
    end

    // Opcode decode: source of the rd value and write / fault classification.
    always_comb begin
        writes_s     = 1'b0;
        illegal_s    = 1'b0;
        misaligned_s = 1'b0;
        value_s      = t_alu_result;
        case (opcode_s)
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC: writes_s = 1'b1;
            OPC_OP32, OPC_OP_IMM32: begin
                if (XLEN == 64) begin
                    writes_s = 1'b1;
                end else begin
                    illegal_s = 1'b1;
                end
            end
            OPC_JAL, OPC_JALR: begin
                writes_s = 1'b1;
                value_s  = t_pc + XLEN'(3'd4);
            end
            OPC_LOAD: begin
                writes_s     = ~load_illegal_s;
                illegal_s    = load_illegal_s;
                misaligned_s = load_misaligned_s;
                value_s      = load_value_s;
            end
            OPC_STORE, OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM: writes_s = 1'b0;
            default: illegal_s = 1'b1;
        endcase
    end

    // Output register: flushed or absent instructions leave data outputs holding.
    always_ff @(posedge clk) begin
        if (!rstf) begin
            rd           <= 5'd0;
            rd_value     <= '0;
            we           <= 1'b0;
            retire_valid <= 1'b0;
            retire_pc    <= '0;
            retire_count <= '0;
            o_misaligned <= 1'b0;
            o_illegal    <= 1'b0;
        end else if (accept_s && !i_flush) begin
            rd           <= rd_s;
            rd_value     <= value_s;
            we           <= writes_s & (rd_s != 5'd0) & ~misaligned_s;
            retire_valid <= 1'b1;
            retire_pc    <= t_pc;
            retire_count <= retire_count + RETIRE_W'(1'b1);
            o_misaligned <= misaligned_s;
            o_illegal    <= illegal_s;
        end else begin
            we           <= 1'b0;
            retire_valid <= 1'b0;
            o_misaligned <= 1'b0;
            o_illegal    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_writeback_stage.sv
// Scoreboard bench for writeback_stage (XLEN=32, RETIRE_W=4): a driver pushes expected
// retires, a negedge monitor pops and compares them against what the DUT presents.
module tb_writeback_stage;
    logic        clk = 1'b0;
    logic        rstf;
    logic [31:0] t_instr, t_pc, t_alu_result, t_load_data;
    logic        t_instr_valid, t_instr_ready, i_hold, i_flush;
    logic [4:0]  rd;
    logic [31:0] rd_value, retire_pc;
    logic        we, retire_valid, o_misaligned, o_illegal;
    logic [3:0]  retire_count;

    writeback_stage #(.XLEN(32), .RETIRE_W(4)) dut (
        .clk(clk), .rstf(rstf), .t_instr(t_instr), .t_instr_valid(t_instr_valid),
        .t_instr_ready(t_instr_ready), .t_pc(t_pc), .t_alu_result(t_alu_result),
        .t_load_data(t_load_data), .i_hold(i_hold), .i_flush(i_flush), .rd(rd),
        .rd_value(rd_value), .we(we), .retire_valid(retire_valid), .retire_pc(retire_pc),
        .retire_count(retire_count), .o_misaligned(o_misaligned), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] val;
        logic [31:0] pc;
        logic        mis;
        logic        ill;
        logic [3:0]  cnt;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   mcount = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] opc, input logic [4:0] r, input logic [2:0] f3);
        return {17'd0, f3, r, opc};
    endfunction

    // Reference: rd value and flags straight from the opcode/funct3 rules, by arithmetic.
    function automatic exp_t model(input logic [31:0] instr, input logic [31:0] alu,
                                   input logic [31:0] ld, input logic [31:0] pc);
        exp_t e;
        int opc, f3, off, size;
        bit writes;
        longint unsigned raw;
        opc = int'(instr[6:0]);
        f3 = int'(instr[14:12]);
        writes = 0;
        e.val = 32'd0; e.mis = 1'b0; e.ill = 1'b0;
        if (opc == 'h33 || opc == 'h13 || opc == 'h37 || opc == 'h17) begin
            writes = 1; e.val = alu;
        end else if (opc == 'h6F || opc == 'h67) begin
            writes = 1; e.val = pc + 32'd4;
        end else if (opc == 'h03) begin
            off = int'(alu % 32'd4);
            size = 1 << (f3 % 4);
            if (f3 == 3 || f3 >= 6) e.ill = 1'b1;
            else if (off % size != 0) e.mis = 1'b1;
            else begin
                raw = (longint'(ld) >> (8 * off)) & ((64'd1 << (8 * size)) - 64'd1);
                if (f3 < 4 && raw >= (64'd1 << (8 * size - 1))) raw = raw - (64'd1 << (8 * size));
                e.val = raw[31:0];
                writes = 1;
            end
        end else if (!(opc == 'h23 || opc == 'h63 || opc == 'h0F || opc == 'h73)) begin
            e.ill = 1'b1;
        end
        e.we = writes && (instr[11:7] != 5'd0) && !e.mis;
        return e;
    endfunction

    // One cycle of stimulus; pushes the expected retire for an accepted, unflushed instruction.
    task automatic step(input logic [31:0] instr, input logic [31:0] pc, input logic [31:0] alu,
                        input logic [31:0] ld, input bit v, input bit hold, input bit flush,
                        input bit rst_n, input bit use_hand, input bit h_we,
                        input logic [31:0] h_val, input bit h_mis, input bit h_ill);
        exp_t e;
        t_instr = instr; t_pc = pc; t_alu_result = alu; t_load_data = ld;
        t_instr_valid = v; i_hold = hold; i_flush = flush; rstf = rst_n;
        #1;
        chk("t_instr_ready", {31'd0, t_instr_ready}, {31'd0, rst_n && !hold});
        if (!rst_n) begin
            mcount = 0;
        end else if (v && !hold && !flush) begin
            if (use_hand) begin
                e.we = h_we; e.val = h_val; e.mis = h_mis; e.ill = h_ill;
            end else begin
                e = model(instr, alu, ld, pc);
            end
            e.rd = instr[11:7];
            e.pc = pc;
            mcount = (mcount + 1) % 16;
            e.cnt = 4'(mcount);
            e.due = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 1, 0, 0, 32'd0, 0, 0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_retire_valid", {31'd0, retire_valid}, 32'd0);
        chk("rst_flags", {30'd0, o_misaligned, o_illegal}, 32'd0);
        chk("rst_rd", {27'd0, rd}, 32'd0);
        chk("rst_rd_value", rd_value, 32'd0);
        chk("rst_retire_pc", retire_pc, 32'd0);
        chk("rst_retire_count", {28'd0, retire_count}, 32'd0);
    endtask

    // Monitor: every presented retire must match the oldest due expectation.
    always @(negedge clk) begin
        exp_t e;
        if (retire_valid === 1'b1) begin
            if (q.size() == 0 || q[0].due != cyc) begin
                checks++; failures++;
                $display("FAIL unexpected_retire actual=pc %h required=no retire (cycle %0d)", retire_pc, cyc);
            end else begin
                e = q.pop_front();
                chk("we", {31'd0, we}, {31'd0, e.we});
                chk("rd", {27'd0, rd}, {27'd0, e.rd});
                if (e.we) chk("rd_value", rd_value, e.val);
                chk("retire_pc", retire_pc, e.pc);
                chk("o_misaligned", {31'd0, o_misaligned}, {31'd0, e.mis});
                chk("o_illegal", {31'd0, o_illegal}, {31'd0, e.ill});
                chk("retire_count", {28'd0, retire_count}, {28'd0, e.cnt});
            end
        end else begin
            if (q.size() != 0 && q[0].due <= cyc) begin
                e = q.pop_front();
                checks++; failures++;
                $display("FAIL missing_retire actual=none required=pc %h (cycle %0d)", e.pc, cyc);
            end
            chk("idle_outputs", {29'd0, we, o_misaligned, o_illegal}, 32'd0);
        end
    end

    logic [6:0] opcs [14] = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h03,
                              7'h03, 7'h23, 7'h63, 7'h0F, 7'h73, 7'h7F, 7'h3B};

    initial begin
        logic [31:0] ins, pc;
        rstf = 1'b0; t_instr_valid = 1'b0; i_hold = 1'b0; i_flush = 1'b0;
        t_instr = 32'd0; t_pc = 32'd0; t_alu_result = 32'd0; t_load_data = 32'd0;
        @(posedge clk); #1;
        step(mk(7'h13, 5'd5, 3'd0), 32'h40, 32'h1234, 32'd0, 1, 0, 0, 0, 0, 0, 32'd0, 0, 0);
        step(32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0);
        check_reset_outputs();
        // Directed cases with hand-written expectations.
        step(mk(7'h13, 5'd5, 3'd0), 32'h40, 32'h1234, 32'd0, 1, 0, 0, 1, 1, 1, 32'h0000_1234, 0, 0);
        step(mk(7'h67, 5'd1, 3'd0), 32'h100, 32'h77, 32'd0, 1, 0, 0, 1, 1, 1, 32'h104, 0, 0);
        step(mk(7'h6F, 5'd0, 3'd0), 32'hFFFF_FFFC, 32'd0, 32'd0, 1, 0, 0, 1, 1, 0, 32'd0, 0, 0);
        step(mk(7'h03, 5'd7, 3'd0), 32'h200, 32'h1003, 32'h80FF_0000, 1, 0, 0, 1, 1, 1, 32'hFFFF_FF80, 0, 0);
        step(mk(7'h03, 5'd8, 3'd5), 32'h204, 32'h1002, 32'h80FF_0000, 1, 0, 0, 1, 1, 1, 32'h0000_80FF, 0, 0);
        step(mk(7'h03, 5'd9, 3'd1), 32'h208, 32'h1001, 32'h80FF_0000, 1, 0, 0, 1, 1, 0, 32'd0, 1, 0);
        step(mk(7'h6F, 5'd3, 3'd0), 32'hFFFF_FFFC, 32'd0, 32'd0, 1, 0, 0, 1, 1, 1, 32'd0, 0, 0);
        for (int i = 0; i < 3; i++)
            step(mk(7'h33, 5'd10, 3'd0), 32'h300, 32'hAAAA, 32'd0, 1, 1, 0, 1, 0, 0, 32'd0, 0, 0);
        step(mk(7'h33, 5'd10, 3'd0), 32'h300, 32'hAAAA, 32'd0, 1, 0, 0, 1, 1, 1, 32'h0000_AAAA, 0, 0);
        step(mk(7'h33, 5'd11, 3'd0), 32'h400, 32'h55, 32'd0, 1, 0, 0, 1, 1, 1, 32'h55, 0, 0);
        step(mk(7'h23, 5'd12, 3'd2), 32'h404, 32'h66, 32'd0, 1, 0, 0, 1, 1, 0, 32'd0, 0, 0);
        step(32'h0000_007F, 32'h408, 32'h77, 32'd0, 1, 0, 0, 1, 1, 0, 32'd0, 0, 1);
        step(mk(7'h33, 5'd13, 3'd0), 32'h40C, 32'h88, 32'd0, 1, 0, 1, 1, 1, 1, 32'h88, 0, 0);
        idle();
        idle();
        // Counter wrap after sixteen retires, then reset in the middle of traffic.
        step(32'd0, 32'd0, 32'd0, 32'd0, 0, 0, 0, 0, 0, 0, 32'd0, 0, 0);
        for (int i = 0; i < 17; i++)
            step(mk(7'h13, 5'(i + 1), 3'd0), 32'h1000 + 32'(4 * i), 32'(i), 32'd0, 1, 0, 0, 1, 0, 0, 32'd0, 0, 0);
        step(mk(7'h13, 5'd4, 3'd0), 32'h2000, 32'h99, 32'd0, 1, 0, 0, 0, 0, 0, 32'd0, 0, 0);
        check_reset_outputs();
        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            ins = mk(opcs[$urandom_range(0, 13)], 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
            ins[31:15] = 17'($urandom);
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            step(ins, pc, $urandom, $urandom, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 2,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 99) != 0, 0, 0, 32'd0, 0, 0);
        end
        idle();
        idle();
        idle();
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
Parametrised, registered successor to the combinational writeback stage. It accepts one instruction per cycle from the memory-access stage, computes the rd value, and presents a one-cycle-registered register-file write. The rd value comes from the ALU result, the load-extracted memory word, or the link PC+4. It adds a stall/flush handshake, load byte/half/word alignment with sign/zero extension, x0 suppression, misalignment/illegal flags and a retire counter. It sits between memory access and the register file.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64 (64 enables LWU/LD).
RETIRE_W, 32, width of retire counter.

Ports:
clk  input  1  clock
rstf  input  1  reset; synchronous, active-low
t_instr  input  32  instruction word
t_instr_valid  input  1  instruction valid
t_instr_ready  output  1  stage can accept
t_pc  input  XLEN  PC of instruction
t_alu_result  input  XLEN  ALU result; the effective address for loads
t_load_data  input  XLEN  raw aligned bus word for loads
i_hold  input  1  register file cannot accept a write this cycle
i_flush  input  1  discard the instruction accepted this cycle
rd  output  5  destination register
rd_value  output  XLEN  write data
we  output  1  register-file write enable
retire_valid  output  1  one-cycle pulse per retired instruction
retire_pc  output  XLEN  PC of retired instruction
retire_count  output  RETIRE_W  retired-instruction count
o_misaligned  output  1  pulse: load address misaligned, write suppressed
o_illegal  output  1  pulse: opcode not recognised, write suppressed

Behaviour:
- Reset (rstf=0 at posedge): we, retire_valid, o_misaligned, o_illegal=0; rd=0; rd_value=0; retire_pc=0; retire_count=0. All flags are held low during reset regardless of t_instr_valid.
- t_instr_ready = rstf & ~i_hold (combinational). Accept = t_instr_valid & t_instr_ready.
- Latency is 1 cycle. All outputs are registered from the accepted instruction. On a non-accept cycle: we, retire_valid and the flags go 0; rd, rd_value and retire_pc hold.
- Flush: accept with i_flush=1 gives no we, no retire, no flag, and no counter change. i_flush without accept is ignored.
- Opcode decode (t_instr[6:0]):
  - OP, OP-IMM, LUI, AUIPC (and OP-32/OP-IMM-32 when XLEN=64) use the ALU result.
  - JAL, JALR use t_pc+4, modulo 2^XLEN; wrap from all-ones-3 gives 0.
  - LOAD uses the extracted load value.
  - STORE, BRANCH, MISC-MEM, SYSTEM retire with no write.
  - Any other opcode retires with no write and o_illegal=1.
- rd = t_instr[11:7]. we = 1 only if the instruction writes, rd != 0, and it is not misaligned. An rd=x0 write still retires; we=0 and rd_value is don't-care.
- Load extraction (funct3 = t_instr[14:12]):
  - Lane offset is t_alu_result[log2(XLEN/8)-1:0].
  - LB/LBU take byte[off]; LH/LHU take halfword at off; LW/LWU take word at off; LD (XLEN=64) takes the full word.
  - Signed forms sign-extend to XLEN; unsigned forms zero-extend.
  - Misaligned when off is not a multiple of the access size (H: off[0]; W: off[1:0]; D: off[2:0]). Result: o_misaligned=1, we=0, instruction still retires.
  - LWU/LD with XLEN=32, or funct3=111, are illegal: o_illegal=1, no write.
- Retire: retire_valid=1 and retire_pc=t_pc for every accepted, non-flushed instruction, including illegal and misaligned ones. retire_count increments by 1 in that cycle and wraps from all-ones to 0.
- A reset arriving while an instruction is accepted takes priority: the instruction is dropped and the counter is cleared.

Test Plan:
- Reset then ADDI x5 with alu=0x1234 → next cycle we=1, rd=5, rd_value=0x00001234, retire_count=1.
- JALR rd=1, pc=0x100 → rd_value=0x104, we=1. JAL rd=0, pc=0xFFFFFFFC → we=0, retire_valid=1, count increments.
- LB at addr 0x...3 with data 0x80FF_0000 → rd_value=0xFFFFFF80. LHU at addr 0x...2 → 0x000080FF. LH at addr 0x...1 → o_misaligned=1, we=0.
- i_hold=1 for 3 cycles with t_instr_valid=1 → t_instr_ready=0, no we, count unchanged. Release → single write and retire.
- Back-to-back ADD, STORE, illegal opcode 0x7F, flushed ADD → we=1,0,0,0; retire_valid=1,1,1,0; o_illegal only on the third; count +3.
- retire_count preset near wrap (RETIRE_W=4, 15 retires) then one more → count=0. rstf low mid-stream → all outputs 0 next cycle.
